reg_writeback: RTL and testbench

- Write-side controller for the MIPS register file. It merges results from the single-cycle ALU path and the multi-cycle memory/muldiv path into the file's single write port (reg_write, reg_d, d).
- It buffers long-latency results in a small FIFO.
- It keeps a pending-register scoreboard so that decode stalls on operands still in flight.
- It sits between the execute/memory stages and the register file, and feeds stall signals back to decode.

---
 rtl/reg_writeback_pkg.sv | 20 ++
 rtl/reg_writeback_if.sv | 36 +++
 rtl/reg_writeback_wb_fifo.sv | 59 +++++
 rtl/reg_writeback.sv | 89 ++++++++
 tb/tb_reg_writeback.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_writeback_pkg.sv
// rtl/reg_writeback_pkg.sv - shared types and constants for the register writeback path
package reg_writeback_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  // r0 is hardwired zero: writes to it are dropped and it is never pending.
  function automatic logic is_real_reg(input logic [REG_W-1:0] r);
    return r != REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// rtl/reg_writeback_if.sv - execute/memory/decode side bundle of the writeback controller
interface reg_writeback_if #(
  parameter int AW = 2
);
  import reg_writeback_pkg::*;

  logic              alu_valid;
  logic [REG_W-1:0]  alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [REG_W-1:0]  mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              issue_valid;
  logic [REG_W-1:0]  issue_reg;
  logic [REG_W-1:0]  reg_s;
  logic [REG_W-1:0]  reg_t;
  logic              stall;
  logic              reg_write;
  logic [REG_W-1:0]  reg_d;
  logic [DATA_W-1:0] d;
  logic [AW:0]       fifo_count;

  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
           issue_valid, issue_reg, reg_s, reg_t,
    input  mem_ready, stall, reg_write, reg_d, d, fifo_count
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
           issue_valid, issue_reg, reg_s, reg_t,
    output mem_ready, stall, reg_write, reg_d, d, fifo_count
  );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// rtl/reg_writeback_wb_fifo.sv - parameterised synchronous FIFO with occupancy count
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Callers may request blindly; the FIFO itself refuses overflow and underflow.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign full_o     = count_q == (AW+1)'(DEPTH);
  assign empty_o    = count_q == '0;
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - merges ALU and long-latency results onto the register-file write port
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_writeback_if.slave bus
);

  logic              reg_write_q, reg_write_d;
  logic [REG_W-1:0]  reg_d_q, reg_d_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [31:0]       pending_q, pending_d;

  logic      alu_sel, push, pop, full, empty;
  wb_entry_t head, in_entry;
  logic [AW:0] count;

  assign in_entry.dst  = bus.mem_reg;
  assign in_entry.data = bus.mem_data;

  // An ALU op to r0 does not claim the port, so the FIFO may drain that cycle.
  assign alu_sel = bus.alu_valid && is_real_reg(bus.alu_reg);
  assign pop     = !alu_sel && !empty;
  assign push    = bus.mem_valid && !full;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (in_entry),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count)
  );

  always_comb begin
    reg_write_d = 1'b0;
    reg_d_d     = reg_d_q;
    d_d         = d_q;
    pending_d   = pending_q;
    if (alu_sel) begin
      reg_write_d = 1'b1;
      reg_d_d     = bus.alu_reg;
      d_d         = bus.alu_data;
    end else if (pop && is_real_reg(head.dst)) begin
      reg_write_d          = 1'b1;
      reg_d_d              = head.dst;
      d_d                  = head.data;
      pending_d[head.dst]  = 1'b0;
    end
    // Applied after the clear so a same-cycle reissue keeps the register pending.
    if (bus.issue_valid && is_real_reg(bus.issue_reg)) begin
      pending_d[bus.issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      reg_d_q     <= REG_ZERO;
      d_q         <= '0;
      pending_q   <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      reg_d_q     <= reg_d_d;
      d_q         <= d_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.mem_ready  = !full;
  assign bus.fifo_count = count;
  assign bus.reg_write  = reg_write_q;
  assign bus.reg_d      = reg_d_q;
  assign bus.d          = d_q;
  assign bus.stall      = (is_real_reg(bus.reg_s) && pending_q[bus.reg_s]) ||
                          (is_real_reg(bus.reg_t) && pending_q[bus.reg_t]);

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed table, reset corner case and random model check of reg_writeback
module tb_reg_writeback;

  logic clk;
  logic rst_n;

  reg_writeback_if #(.AW(2)) bus ();

  reg_writeback #(.DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_r;
    logic [31:0] alu_d;
    logic        mem_v;
    logic [4:0]  mem_r;
    logic [31:0] mem_d;
    logic        iss_v;
    logic [4:0]  iss_r;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_d;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic        e_stall;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  int vectors;
  int miscompares;
  vec_t tbl[27];

  function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                              logic mv, logic [4:0] mr, logic [31:0] md,
                              logic iv, logic [4:0] ir, logic [4:0] rs, logic [4:0] rt,
                              logic wr, logic [4:0] rd, logic [31:0] dd,
                              logic [2:0] cnt, logic rdy, logic st);
    vec_t v;
    v.alu_v = av; v.alu_r = ar; v.alu_d = ad;
    v.mem_v = mv; v.mem_r = mr; v.mem_d = md;
    v.iss_v = iv; v.iss_r = ir; v.rs = rs; v.rt = rt;
    v.e_wr = wr; v.e_rd = rd; v.e_d = dd;
    v.e_cnt = cnt; v.e_rdy = rdy; v.e_stall = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.alu_valid   = v.alu_v;
    bus.alu_reg     = v.alu_r;
    bus.alu_data    = v.alu_d;
    bus.mem_valid   = v.mem_v;
    bus.mem_reg     = v.mem_r;
    bus.mem_data    = v.mem_d;
    bus.issue_valid = v.iss_v;
    bus.issue_reg   = v.iss_r;
    bus.reg_s       = v.rs;
    bus.reg_t       = v.rt;
  endtask

  task automatic idle();
    apply(mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 0,0,0));
  endtask

  ent_t        q[$];
  bit          pend[32];
  logic        m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_d;

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    idle();

    tbl[0]  = mk(0,0,0,          0,0,0,          0,0, 0,0, 0,0,'h0,     0,1,0);
    tbl[1]  = mk(1,3,'h1234,     0,0,0,          0,0, 0,0, 1,3,'h1234,  0,1,0);
    tbl[2]  = mk(1,0,'hDEAD,     0,0,0,          0,0, 0,0, 0,3,'h1234,  0,1,0);
    tbl[3]  = mk(1,7,'h77,       1,5,'hAA,       0,0, 0,0, 1,7,'h77,    1,1,0);
    tbl[4]  = mk(1,7,'h78,       0,0,0,          0,0, 0,0, 1,7,'h78,    1,1,0);
    tbl[5]  = mk(0,0,0,          0,0,0,          0,0, 0,0, 1,5,'hAA,    0,1,0);
    tbl[6]  = mk(1,1,'h11,       1,10,'h100,     0,0, 0,0, 1,1,'h11,    1,1,0);
    tbl[7]  = mk(1,1,'h12,       1,11,'h101,     0,0, 0,0, 1,1,'h12,    2,1,0);
    tbl[8]  = mk(1,1,'h13,       1,12,'h102,     0,0, 0,0, 1,1,'h13,    3,1,0);
    tbl[9]  = mk(1,1,'h14,       1,13,'h103,     0,0, 0,0, 1,1,'h14,    4,0,0);
    tbl[10] = mk(1,1,'h15,       1,14,'h104,     0,0, 0,0, 1,1,'h15,    4,0,0);
    tbl[11] = mk(0,0,0,          1,14,'h104,     0,0, 0,0, 1,10,'h100,  3,1,0);
    tbl[12] = mk(0,0,0,          1,14,'h104,     0,0, 0,0, 1,11,'h101,  3,1,0);
    tbl[13] = mk(0,0,0,          0,0,0,          0,0, 0,0, 1,12,'h102,  2,1,0);
    tbl[14] = mk(0,0,0,          0,0,0,          0,0, 0,0, 1,13,'h103,  1,1,0);
    tbl[15] = mk(0,0,0,          0,0,0,          0,0, 0,0, 1,14,'h104,  0,1,0);
    tbl[16] = mk(0,0,0,          0,0,0,          0,0, 0,0, 0,14,'h104,  0,1,0);
    tbl[17] = mk(0,0,0,          0,0,0,          1,9, 9,0, 0,14,'h104,  0,1,1);
    tbl[18] = mk(0,0,0,          1,9,'h99,       0,0, 9,0, 0,14,'h104,  1,1,1);
    tbl[19] = mk(0,0,0,          0,0,0,          0,0, 9,0, 1,9,'h99,    0,1,0);
    tbl[20] = mk(0,0,0,          1,9,'h9A,       1,9, 0,9, 0,9,'h99,    1,1,1);
    tbl[21] = mk(0,0,0,          0,0,0,          1,9, 0,9, 1,9,'h9A,    0,1,1);
    tbl[22] = mk(0,0,0,          0,0,0,          0,0, 0,0, 0,9,'h9A,    0,1,0);
    tbl[23] = mk(0,0,0,          1,0,'h55,       0,0, 0,0, 0,9,'h9A,    1,1,0);
    tbl[24] = mk(1,0,'h66,       0,0,0,          0,0, 9,0, 0,9,'h9A,    0,1,1);
    tbl[25] = mk(1,0,'h67,       1,6,'h60,       0,0, 0,0, 0,9,'h9A,    1,1,0);
    tbl[26] = mk(1,0,'h68,       0,0,0,          0,0, 0,0, 1,6,'h60,    0,1,0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset reg_write", 32'(bus.reg_write), 0);
    chk("reset fifo_count", 32'(bus.fifo_count), 0);
    chk("reset mem_ready", 32'(bus.mem_ready), 1);
    chk("reset stall", 32'(bus.stall), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      apply(tbl[i]);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d reg_write", i), 32'(bus.reg_write), 32'(tbl[i].e_wr));
      chk($sformatf("row%0d reg_d", i), 32'(bus.reg_d), 32'(tbl[i].e_rd));
      chk($sformatf("row%0d d", i), bus.d, tbl[i].e_d);
      chk($sformatf("row%0d fifo_count", i), 32'(bus.fifo_count), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d mem_ready", i), 32'(bus.mem_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d stall", i), 32'(bus.stall), 32'(tbl[i].e_stall));
    end

    // Reset in the middle of traffic: three buffered entries and r4 pending.
    apply(mk(1,2,'h21, 1,20,'h200, 1,4, 0,0, 0,0,0, 0,0,0));
    @(posedge clk); #1;
    apply(mk(1,2,'h22, 1,21,'h201, 0,0, 0,0, 0,0,0, 0,0,0));
    @(posedge clk); #1;
    apply(mk(1,2,'h23, 1,22,'h202, 0,0, 4,0, 0,0,0, 0,0,0));
    @(posedge clk); #1;
    chk("pre-reset fifo_count", 32'(bus.fifo_count), 3);
    chk("pre-reset reg_write", 32'(bus.reg_write), 1);
    chk("pre-reset stall", 32'(bus.stall), 1);
    idle();
    bus.reg_s = 5'd4;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset fifo_count", 32'(bus.fifo_count), 0);
    chk("async reset reg_write", 32'(bus.reg_write), 0);
    chk("async reset stall", 32'(bus.stall), 0);
    chk("async reset mem_ready", 32'(bus.mem_ready), 1);
    chk("async reset reg_d", 32'(bus.reg_d), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post-reset%0d reg_write", i), 32'(bus.reg_write), 0);
      chk($sformatf("post-reset%0d fifo_count", i), 32'(bus.fifo_count), 0);
    end

    // Random traffic against a queue-level model; register indices kept small for collisions.
    q.delete();
    for (int r = 0; r < 32; r++) pend[r] = 1'b0;
    m_rd = 5'd0;
    m_d  = 32'd0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      vec_t v;
      ent_t e;
      bit   was_full;
      v = mk($urandom_range(0,9) < 4, 5'($urandom_range(0,7)), $urandom,
             $urandom_range(0,1) == 1, 5'($urandom_range(0,7)), $urandom,
             $urandom_range(0,3) == 0, 5'($urandom_range(0,7)),
             5'($urandom_range(0,7)), 5'($urandom_range(0,7)), 0,0,0, 0,0,0);
      was_full = q.size() == 4;
      m_wr = 1'b0;
      if (v.alu_v && v.alu_r != 0) begin
        m_wr = 1'b1; m_rd = v.alu_r; m_d = v.alu_d;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        if (e.r != 0) begin
          m_wr = 1'b1; m_rd = e.r; m_d = e.d;
          pend[e.r] = 1'b0;
        end
      end
      if (v.mem_v && !was_full) begin
        e.r = v.mem_r; e.d = v.mem_d;
        q.push_back(e);
      end
      if (v.iss_v && v.iss_r != 0) pend[v.iss_r] = 1'b1;
      apply(v);
      @(posedge clk); #1;
      chk($sformatf("rand%0d reg_write", cyc), 32'(bus.reg_write), 32'(m_wr));
      if (m_wr) begin
        chk($sformatf("rand%0d reg_d", cyc), 32'(bus.reg_d), 32'(m_rd));
        chk($sformatf("rand%0d d", cyc), bus.d, m_d);
      end
      chk($sformatf("rand%0d fifo_count", cyc), 32'(bus.fifo_count), q.size());
      chk($sformatf("rand%0d mem_ready", cyc), 32'(bus.mem_ready), 32'(q.size() != 4));
      chk($sformatf("rand%0d stall", cyc), 32'(bus.stall),
          32'((v.rs != 0 && pend[v.rs]) || (v.rt != 0 && pend[v.rt])));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
